// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
//   MODE_ROUTE / MODE_BCAST : values of the mode input
//   DROP_W                  : width of the dropped-transfer counter
//   calc_sel_w()            : channel-select width, never less than one bit
package demux_pkg;

  localparam logic MODE_ROUTE = 1'b0;
  localparam logic MODE_BCAST = 1'b1;

  localparam int unsigned DROP_W = 8;

  // max(1, ceil(log2(n)))
  function automatic int unsigned calc_sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// One-entry output buffer for a single demux channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : load din (may coincide with pop for a bubble-free handoff)
//   pop        : downstream consumed the held entry
//   din        : payload to load
//   full       : entry is held
//   dout       : held payload (retains last value once empty)
module demux_chan_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  // Push wins over pop so a same-cycle pop-and-push keeps the entry full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (push) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1xn_stream.sv
// 1-to-N valid/ready stream demultiplexer with per-channel one-entry buffers.
//   clk, rst_n : clock, asynchronous active-low reset
//   sel        : destination channel index (0 = first channel)
//   mode       : MODE_ROUTE sends to sel, MODE_BCAST loads every channel
//   in_valid / in_ready / in_data    : upstream handshake and payload
//   out_valid / out_ready / out_data : per-channel handshakes, channel k at
//                                      out_data[k*WIDTH +: WIDTH]
//   err        : sticky, an accepted routed transfer had an out-of-range sel
//   err_clr    : synchronous clear of err and drop_cnt
//   drop_cnt   : dropped transfers, saturating at 255
module demux_1xn_stream
  import demux_pkg::*;
#(
  parameter  int unsigned N_OUT = 5,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = calc_sel_w(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic                   err,
  input  logic                   err_clr,
  output logic [DROP_W-1:0]      drop_cnt
);

  logic [N_OUT-1:0] full;
  logic [N_OUT-1:0] pop;
  logic [N_OUT-1:0] writable;
  logic [N_OUT-1:0] sel_hit;
  logic [N_OUT-1:0] push;
  logic             sel_ok;
  logic             xfer;
  logic             drop;

  // Handshake and steering; in_ready is built without in_valid.
  always_comb begin
    sel_hit  = '0;
    push     = '0;
    drop     = 1'b0;
    in_ready = 1'b0;

    for (int unsigned k = 0; k < N_OUT; k++) begin
      sel_hit[k] = (32'(sel) == k);
    end
    // Constant-true when N_OUT is a power of two, so the drop path folds away.
    sel_ok   = (32'(sel) < N_OUT);
    pop      = full & out_ready;
    writable = ~full | pop;

    if (mode == MODE_BCAST) begin
      in_ready = &writable;
    end else if (sel_ok) begin
      in_ready = |(sel_hit & writable);
    end else begin
      in_ready = 1'b1;
    end

    xfer = in_valid & in_ready;
    if (xfer) begin
      if (mode == MODE_BCAST) begin
        push = '1;
      end else if (sel_ok) begin
        push = sel_hit;
      end else begin
        drop = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_chan
    demux_chan_buf #(
      .WIDTH (WIDTH)
    ) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (in_data),
      .full  (full[k]),
      .dout  (out_data[k*WIDTH +: WIDTH])
    );
  end

  assign out_valid = full;

  // Sticky error and saturating drop counter; clear beats a simultaneous drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      drop_cnt <= '0;
    end else if (err_clr) begin
      err      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      err <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Self-checking bench for demux_1xn_stream (N_OUT=5, WIDTH=8): directed steps
// plus a per-channel scoreboard filled at acceptance and drained at pops.
module tb_demux_1xn_stream;

  localparam int unsigned N = 5;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [2:0]     sel = '0;
  logic           mode = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready = '1;
  logic [N*W-1:0] out_data;
  logic           err;
  logic           err_clr = 1'b0;
  logic [7:0]     drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, advanced at every falling edge.
  logic [W-1:0] sb [N][$];
  logic [N-1:0] m_full = '0;
  logic         m_err = 1'b0;
  logic [7:0]   m_cnt = '0;

  demux_1xn_stream #(
    .N_OUT (N),
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err),
    .err_clr   (err_clr),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard / model: check outputs, then predict the next rising edge.
  always @(negedge clk) begin
    logic [N-1:0] m_wr;
    logic         exp_rdy;
    logic         sel_ok;
    if (!rst_n) begin
      m_full = '0;
      m_err  = 1'b0;
      m_cnt  = '0;
      for (int k = 0; k < N; k++) sb[k].delete();
    end else begin
      chk("sb_out_valid", 64'(out_valid), 64'(m_full));
      chk("sb_err", 64'(err), 64'(m_err));
      chk("sb_drop_cnt", 64'(drop_cnt), 64'(m_cnt));
      for (int k = 0; k < N; k++) begin
        if (m_full[k]) begin
          if (sb[k].size() == 0) chk("sb_underflow", 64'(1), 64'(0));
          else chk("sb_out_data", 64'(out_data[k*W +: W]), 64'(sb[k][0]));
        end
      end
      m_wr   = ~m_full | (m_full & out_ready);
      sel_ok = (int'(sel) < N);
      if (mode) exp_rdy = &m_wr;
      else if (sel_ok) exp_rdy = m_wr[sel];
      else exp_rdy = 1'b1;
      chk("sb_in_ready", 64'(in_ready), 64'(exp_rdy));
      for (int k = 0; k < N; k++) begin
        if (m_full[k] && out_ready[k]) begin
          void'(sb[k].pop_front());
          m_full[k] = 1'b0;
        end
      end
      if (in_valid && exp_rdy) begin
        if (mode) begin
          for (int k = 0; k < N; k++) begin
            sb[k].push_back(in_data);
            m_full[k] = 1'b1;
          end
        end else if (sel_ok) begin
          sb[sel].push_back(in_data);
          m_full[sel] = 1'b1;
        end
      end
      if (err_clr) begin
        m_err = 1'b0;
        m_cnt = '0;
      end else if (in_valid && exp_rdy && !mode && !sel_ok) begin
        m_err = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    rst_n = 1'b1;
    cyc();

    // Routed one-hot walk across all channels
    out_ready = 5'b11111;
    mode      = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sel     = 3'(i);
      in_data = 8'(8'h10 + i);
      cyc();
      chk("route_valid", 64'(out_valid), 64'(5'b00001 << i));
      chk("route_data", 64'(out_data[i*W +: W]), 64'(8'h10 + i));
    end
    in_valid = 1'b0;
    cyc();
    chk("route_drain", 64'(out_valid), 64'h0);

    // Invalid select: dropped, flagged, counted, then cleared
    in_valid = 1'b1;
    for (int i = 5; i < 8; i++) begin
      sel = 3'(i);
      #1;
      chk("bad_sel_ready", 64'(in_ready), 64'h1);
      cyc();
    end
    in_valid = 1'b0;
    chk("bad_sel_valid", 64'(out_valid), 64'h0);
    chk("bad_sel_err", 64'(err), 64'h1);
    chk("bad_sel_cnt", 64'(drop_cnt), 64'd3);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr_err", 64'(err), 64'h0);
    chk("clr_cnt", 64'(drop_cnt), 64'h0);

    // Clear wins over a simultaneous drop
    sel = 3'd6; in_valid = 1'b1; err_clr = 1'b1;
    cyc();
    in_valid = 1'b0; err_clr = 1'b0;
    chk("clr_win_err", 64'(err), 64'h0);
    chk("clr_win_cnt", 64'(drop_cnt), 64'h0);

    // Backpressure on channel 2, then bubble-free pop-and-push
    out_ready = 5'b11011;
    sel = 3'd2; in_data = 8'h21; in_valid = 1'b1;
    #1;
    chk("bp_first_ready", 64'(in_ready), 64'h1);
    cyc();
    in_data = 8'h22;
    #1;
    chk("bp_second_block", 64'(in_ready), 64'h0);
    cyc();
    chk("bp_still_block", 64'(in_ready), 64'h0);
    chk("bp_held_valid", 64'(out_valid), 64'(5'b00100));
    chk("bp_held_data", 64'(out_data[2*W +: W]), 64'h21);
    out_ready = 5'b11111;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'h1);
    cyc();
    in_valid = 1'b0;
    chk("bp_nobubble_valid", 64'(out_valid), 64'(5'b00100));
    chk("bp_nobubble_data", 64'(out_data[2*W +: W]), 64'h22);
    cyc();
    chk("bp_drain", 64'(out_valid), 64'h0);

    // Broadcast blocked by a full channel 3, then released
    out_ready = 5'b10111;
    sel = 3'd3; in_data = 8'h33; in_valid = 1'b1;
    cyc();
    mode = 1'b1; sel = 3'd7; in_data = 8'hA5;
    #1;
    chk("bc_block", 64'(in_ready), 64'h0);
    cyc();
    chk("bc_still_block", 64'(in_ready), 64'h0);
    chk("bc_held_valid", 64'(out_valid), 64'(5'b01000));
    out_ready = 5'b11111;
    #1;
    chk("bc_release_ready", 64'(in_ready), 64'h1);
    cyc();
    in_valid = 1'b0; out_ready = 5'b00000;
    chk("bc_all_valid", 64'(out_valid), 64'(5'b11111));
    chk("bc_all_data", 64'(out_data), 64'hA5A5A5A5A5);
    chk("bc_no_err", 64'(err), 64'h0);
    out_ready = 5'b11111;
    cyc();
    chk("bc_drain", 64'(out_valid), 64'h0);
    mode = 1'b0;

    // Drop counter saturation
    sel = 3'd7; in_valid = 1'b1;
    repeat (300) cyc();
    in_valid = 1'b0;
    chk("sat_cnt", 64'(drop_cnt), 64'd255);
    chk("sat_err", 64'(err), 64'h1);

    // Asynchronous reset while holding data; no transfer on a reset edge
    mode = 1'b1; in_data = 8'h5A; out_ready = 5'b00000; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; mode = 1'b0; sel = 3'd0;
    chk("pre_rst_valid", 64'(out_valid), 64'(5'b11111));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'h0);
    chk("async_rst_err", 64'(err), 64'h0);
    chk("async_rst_cnt", 64'(drop_cnt), 64'h0);
    chk("async_rst_data", 64'(out_data), 64'h0);
    chk("async_rst_ready", 64'(in_ready), 64'h1);
    in_valid = 1'b1; in_data = 8'h77;
    cyc();
    chk("rst_edge_no_xfer", 64'(out_valid), 64'h0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    out_ready = 5'b11111;
    cyc();
    chk("post_rst_valid", 64'(out_valid), 64'h0);
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1xn_stream.md
DEMUX_1XN_STREAM -- requirements
Module: demux_1xn_stream

Interface
REQ-001 Parameter N_OUT, default 5, number of output channels, legal range 2..16.
REQ-002 Parameter WIDTH, default 8, payload bits per transfer, legal range 1..64.
REQ-003 Derived constant SEL_W = max(1, ceil(log2(N_OUT))) SHALL set the Sel width.
REQ-004 Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous and active-low.
REQ-006 Sel  input  SEL_W  destination channel index; channel k maps to Outk+1 numbering (index 0 = Out1).
REQ-007 Mode  input  1  0 = route to Sel, 1 = broadcast to all channels.
REQ-008 In_valid  input  1  upstream offers In_data.
REQ-009 In_ready  output  1  block accepts the offer this cycle.
REQ-010 In_data  input  WIDTH  payload.
REQ-011 Out_valid  output  N_OUT  per-channel data available.
REQ-012 Out_ready  input  N_OUT  per-channel downstream acceptance.
REQ-013 Out_data  output  N_OUT*WIDTH  per-channel payload; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-014 Err  output  1  sticky flag: an accepted transfer carried an invalid Sel.
REQ-015 Err_clr  input  1  synchronous clear of Err and Drop_cnt.
REQ-016 Drop_cnt  output  8  count of dropped transfers, saturating at 255.

Function
REQ-017 Each channel SHALL hold a one-entry buffer (full flag + WIDTH data); Out_valid[k] = full[k] and Out_data slice = buffer data.
REQ-018 A transfer SHALL occur when In_valid and In_ready are both 1 on a rising edge; the written data SHALL appear on Out_valid/Out_data the next cycle (latency 1).
REQ-019 Channel k is writable when it is not full, or when Out_valid[k] and Out_ready[k] are both 1 in the same cycle (pop-and-push, no bubble).
REQ-020 Route mode with Sel < N_OUT: In_ready SHALL equal writable[Sel]; only channel Sel SHALL be loaded.
REQ-021 Route mode with Sel >= N_OUT: In_ready SHALL be 1; an accepted transfer SHALL be dropped, set Err, and increment Drop_cnt; no channel SHALL change.
REQ-022 Broadcast mode: In_ready SHALL be the AND of writable over all channels; an accepted transfer SHALL load every channel; Sel is ignored and never raises Err.
REQ-023 A channel SHALL clear full when popped (Out_valid & Out_ready) and not reloaded in the same cycle.
REQ-024 In_ready SHALL depend combinationally only on Sel, Mode, the full flags and Out_ready; it SHALL NOT depend on In_valid.
REQ-025 Drop_cnt SHALL hold at 255 on further drops; Err SHALL remain 1 until Err_clr or reset.
REQ-026 Err_clr asserted with a simultaneous drop: clear SHALL win (Err = 0, Drop_cnt = 0).
REQ-027 Out_data of an empty channel SHALL retain its last value; it is don't-care for checking.
REQ-028 When N_OUT is a power of two, the invalid-Sel path is unreachable and SHALL synthesise away.

Reset
REQ-029 Reset_n low SHALL immediately clear all full flags, Err and Drop_cnt, and zero all buffer data; Out_valid SHALL be all 0 and In_ready SHALL follow REQ-020..022 with empty buffers.
REQ-030 Reset mid-transfer SHALL discard all buffered data; no transfer SHALL complete on the edge at which Reset_n is low.

Structure
REQ-031 Package demux_pkg SHALL hold the SEL_W computation function and the MODE_ROUTE/MODE_BCAST constants.
REQ-032 Sub-module demux_chan_buf (one-entry buffer with push, pop, full, data) SHALL be instantiated N_OUT times via generate.

Verification
REQ-033 N_OUT=5, Mode=0, Out_ready all 1, Sel 0..4 with In_data 0x10..0x14 on successive cycles -> Out_valid one-hot 00001..10000 one cycle later, data matching.
REQ-034 Mode=0, Sel=5,6,7 with In_valid=1 -> In_ready=1, Out_valid stays 0, Err=1, Drop_cnt=3; then Err_clr=1 -> Err=0, Drop_cnt=0.
REQ-035 Out_ready[2]=0, two transfers to Sel=2 -> first buffered, In_ready=0 for the second until Out_ready[2]=1; on that cycle pop-and-push completes with no bubble.
REQ-036 Mode=1, In_data=0xA5, Out_ready[3]=0 with channel 3 full -> In_ready=0; after Out_ready[3]=1 -> all five channels valid with 0xA5.
REQ-037 300 invalid-Sel drops -> Drop_cnt saturates at 255.
REQ-038 Reset_n pulsed low while channels hold data -> Out_valid=0 immediately, Err=0, Drop_cnt=0.
